// File: rtl/enc_pkg.sv
// enc_pkg: shared FSM state type and width/pointer helpers for the sequential priority encoder.
package enc_pkg;

   typedef enum logic {IDLE, DRAIN} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int inc_mod(input int v, input int n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_find_first.sv
// rr_find_first: first set bit of vec scanning circularly from start, plus a one-hot flag.
module rr_find_first
   import enc_pkg::*;
#(
   parameter int N = 8,
   localparam int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     vec,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             found,
   output logic             single
);

   logic [2*N-1:0] masked;

   // The doubled copy lets a plain lowest-first scan wrap past N-1 back to 0.
   assign masked = {vec, vec} & ({(2*N){1'b1}} << start);

   always_comb begin
      idx = '0;
      found = 1'b0;
      for (int j = 2*N-1; j >= 0; j--)
         if (masked[j]) begin
            idx = IDX_W'(j >= N ? j - N : j);
            found = 1'b1;
         end
   end

   assign single = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder: accepts a request vector and serially emits the index of every set bit.
module seq_priority_encoder
   import enc_pkg::*;
#(
   parameter int N = 8,
   parameter bit RR = 1'b0,
   localparam int IDX_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_vec,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             zero_seen
);

   state_t           state;
   logic [N-1:0]     pending;
   logic [IDX_W-1:0] ptr;
   logic             found;

   rr_find_first #(.N(N)) u_find (
      .vec   (pending),
      .start (RR ? ptr : '0),
      .idx   (out_idx),
      .found (found),
      .single(out_last)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DRAIN) && found;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         ptr       <= '0;
         zero_seen <= 1'b0;
      end else begin
         zero_seen <= 1'b0;
         if (state == IDLE) begin
            if (in_valid) begin
               if (in_vec == '0) zero_seen <= 1'b1;
               else begin
                  pending <= in_vec;
                  state   <= DRAIN;
               end
            end
         end else if (out_ready) begin
            pending <= pending & ~(N'(1) << out_idx);
            if (RR) ptr <= IDX_W'(inc_mod(int'(out_idx), N));
            if (out_last) state <= IDLE;
         end
      end

endmodule
